garage_door_ctrl: RTL and testbench

- Moore-style controller for a single garage-door motor.
- On an Activate request it drives the motor up or down, depending on which end-stop the door is resting at.
- It stops the motor when the opposite end-stop is reached.
- Sits between the wall-button/limit-switch inputs and the motor driver; two one-hot motor commands out.

---
 rtl/garage_pkg.sv | 31 +++
 rtl/garage_door_ctrl.sv | 59 +++++
 tb/tb_garage_door_ctrl.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/garage_pkg.sv
// Shared definitions for the garage door motor controller: state encoding
// and the per-state motor command decode.
package garage_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        MV_UP = 2'b01,
        MV_DN = 2'b10
    } door_state_t;

    typedef struct packed {
        logic up;
        logic dn;
    } motor_cmd_t;

    localparam motor_cmd_t MOTOR_IDLE = '{up: 1'b0, dn: 1'b0};
    localparam motor_cmd_t MOTOR_UP   = '{up: 1'b1, dn: 1'b0};
    localparam motor_cmd_t MOTOR_DN   = '{up: 1'b0, dn: 1'b1};

    // Anything outside the three legal states decodes to a stopped motor.
    function automatic motor_cmd_t decode_motor(input door_state_t s);
        motor_cmd_t cmd;
        case (s)
            MV_UP:   cmd = MOTOR_UP;
            MV_DN:   cmd = MOTOR_DN;
            default: cmd = MOTOR_IDLE;
        endcase
        return cmd;
    endfunction

endpackage

// File: rtl/garage_door_ctrl.sv
// Moore controller for a single garage door motor: starts the door moving
// away from whichever end-stop it rests at and stops at the opposite one.
module garage_door_ctrl
    import garage_pkg::*;
(
    input  logic CLK,
    input  logic RST,
    input  logic Activate,
    input  logic Up_MAX,
    input  logic Dn_MAX,
    output logic UP_M,
    output logic DN_M
);

    door_state_t state;
    door_state_t state_nxt;
    motor_cmd_t  cmd_nxt;

    always_comb begin
        state_nxt = IDLE;
        case (state)
            IDLE: begin
                if (Activate && Dn_MAX && !Up_MAX)
                    state_nxt = MV_UP;
                else if (Activate && Up_MAX && !Dn_MAX)
                    state_nxt = MV_DN;
                else
                    state_nxt = IDLE;
            end
            MV_UP:   state_nxt = Up_MAX ? IDLE : MV_UP;
            MV_DN:   state_nxt = Dn_MAX ? IDLE : MV_DN;
            default: state_nxt = IDLE;
        endcase
    end

    assign cmd_nxt = decode_motor(state_nxt);

    // Outputs are registered from the decoded next state, so they always
    // match the state register and carry no combinational input path.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state <= IDLE;
            UP_M  <= 1'b0;
            DN_M  <= 1'b0;
        end else begin
            state <= state_nxt;
            UP_M  <= cmd_nxt.up;
            DN_M  <= cmd_nxt.dn;
        end
    end

`ifndef SYNTHESIS
    a_motor_exclusive: assert property (@(posedge CLK) disable iff (!RST)
        !(UP_M && DN_M));
    a_outputs_match_state: assert property (@(posedge CLK) disable iff (!RST)
        {UP_M, DN_M} == {decode_motor(state).up, decode_motor(state).dn});
`endif

endmodule

// File: tb/tb_garage_door_ctrl.sv
// Self-checking bench for garage_door_ctrl: directed scenarios plus
// randomized traffic against a direction-based reference model.
module tb_garage_door_ctrl;

    logic CLK = 1'b0;
    logic RST;
    logic Activate;
    logic Up_MAX;
    logic Dn_MAX;
    logic UP_M;
    logic DN_M;

    int unsigned pass_cnt  = 0;
    int unsigned total_cnt = 0;

    // Reference model: +1 door travelling up, -1 travelling down, 0 stopped.
    int dir = 0;

    garage_door_ctrl dut (
        .CLK      (CLK),
        .RST      (RST),
        .Activate (Activate),
        .Up_MAX   (Up_MAX),
        .Dn_MAX   (Dn_MAX),
        .UP_M     (UP_M),
        .DN_M     (DN_M)
    );

    always #10 CLK = ~CLK;

    // Apply inputs on the falling edge, clock once, advance the model and
    // settle 1 ns past the rising edge so outputs can be sampled.
    task automatic step(input logic a, input logic up, input logic dn);
        @(negedge CLK);
        Activate = a;
        Up_MAX   = up;
        Dn_MAX   = dn;
        @(posedge CLK);
        if (dir == 0) begin
            if (a && dn && !up)      dir = 1;
            else if (a && up && !dn) dir = -1;
        end else if (dir == 1) begin
            if (up) dir = 0;
        end else begin
            if (dn) dir = 0;
        end
        #1;
    endtask

    task automatic test_reset();
        RST = 1'b0; Activate = 1'b1; Dn_MAX = 1'b1; Up_MAX = 1'b0;
        #2;
        total_cnt++;
        if ({UP_M, DN_M} !== 2'b00)
            $display("FAIL reset_hold: got UP_M,DN_M=%b, want 00", {UP_M, DN_M});
        else pass_cnt++;
        repeat (2) @(posedge CLK);
        #1;
        total_cnt++;
        if ({UP_M, DN_M} !== 2'b00)
            $display("FAIL reset_edges: got UP_M,DN_M=%b, want 00", {UP_M, DN_M});
        else pass_cnt++;
        @(negedge CLK);
        Activate = 1'b0; Dn_MAX = 1'b0;
        RST = 1'b1;
        dir = 0;
    endtask

    task automatic test_open();
        step(1'b1, 1'b0, 1'b1);
        total_cnt++;
        if ({UP_M, DN_M} !== 2'b10)
            $display("FAIL open_start: got %b, want 10", {UP_M, DN_M});
        else pass_cnt++;
        for (int unsigned i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, 1'b0);
            total_cnt++;
            if ({UP_M, DN_M} !== 2'b10)
                $display("FAIL open_travel[%0d]: got %b, want 10", i, {UP_M, DN_M});
            else pass_cnt++;
        end
        step(1'b0, 1'b1, 1'b0);
        total_cnt++;
        if ({UP_M, DN_M} !== 2'b00)
            $display("FAIL open_stop: got %b, want 00", {UP_M, DN_M});
        else pass_cnt++;
    endtask

    task automatic test_close();
        step(1'b1, 1'b1, 1'b0);
        total_cnt++;
        if ({UP_M, DN_M} !== 2'b01)
            $display("FAIL close_start: got %b, want 01", {UP_M, DN_M});
        else pass_cnt++;
        for (int unsigned i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, 1'b0);
            total_cnt++;
            if ({UP_M, DN_M} !== 2'b01)
                $display("FAIL close_travel[%0d]: got %b, want 01", i, {UP_M, DN_M});
            else pass_cnt++;
        end
        step(1'b0, 1'b0, 1'b1);
        total_cnt++;
        if ({UP_M, DN_M} !== 2'b00)
            $display("FAIL close_stop: got %b, want 00", {UP_M, DN_M});
        else pass_cnt++;
    endtask

    task automatic test_illegal();
        step(1'b1, 1'b0, 1'b0);
        total_cnt++;
        if ({UP_M, DN_M} !== 2'b00)
            $display("FAIL illegal_midtravel: got %b, want 00", {UP_M, DN_M});
        else pass_cnt++;
        step(1'b1, 1'b1, 1'b1);
        total_cnt++;
        if ({UP_M, DN_M} !== 2'b00)
            $display("FAIL illegal_both_limits: got %b, want 00", {UP_M, DN_M});
        else pass_cnt++;
        step(1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_activate_ignored();
        step(1'b1, 1'b0, 1'b1);
        for (int unsigned i = 0; i < 2; i++) begin
            step(1'b1, 1'b0, 1'b0);
            total_cnt++;
            if ({UP_M, DN_M} !== 2'b10)
                $display("FAIL act_ignored[%0d]: got %b, want 10", i, {UP_M, DN_M});
            else pass_cnt++;
        end
        // Activate held through the stop: door is now open, so it reverses next.
        step(1'b1, 1'b1, 1'b0);
        total_cnt++;
        if ({UP_M, DN_M} !== 2'b00)
            $display("FAIL act_top_stop: got %b, want 00", {UP_M, DN_M});
        else pass_cnt++;
        step(1'b1, 1'b1, 1'b0);
        total_cnt++;
        if ({UP_M, DN_M} !== 2'b01)
            $display("FAIL act_level_retrigger: got %b, want 01", {UP_M, DN_M});
        else pass_cnt++;
        step(1'b0, 1'b0, 1'b1);
        total_cnt++;
        if ({UP_M, DN_M} !== 2'b00)
            $display("FAIL act_bottom_stop: got %b, want 00", {UP_M, DN_M});
        else pass_cnt++;
    endtask

    task automatic test_async_reset();
        step(1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        total_cnt++;
        if ({UP_M, DN_M} !== 2'b01)
            $display("FAIL areset_pre: got %b, want 01", {UP_M, DN_M});
        else pass_cnt++;
        @(negedge CLK);
        #5;
        RST = 1'b0;
        #1;
        dir = 0;
        total_cnt++;
        if ({UP_M, DN_M} !== 2'b00)
            $display("FAIL areset_immediate: got %b, want 00", {UP_M, DN_M});
        else pass_cnt++;
        @(negedge CLK);
        Activate = 1'b0;
        RST = 1'b1;
        step(1'b0, 1'b0, 1'b0);
        total_cnt++;
        if ({UP_M, DN_M} !== 2'b00)
            $display("FAIL areset_release: got %b, want 00", {UP_M, DN_M});
        else pass_cnt++;
    endtask

    task automatic test_random();
        logic a, up, dn;
        logic exp_up, exp_dn;
        for (int unsigned i = 0; i < 400; i++) begin
            a  = ($urandom_range(0, 2) != 0);
            up = ($urandom_range(0, 3) == 0);
            dn = ($urandom_range(0, 3) == 0);
            step(a, up, dn);
            exp_up = (dir == 1);
            exp_dn = (dir == -1);
            total_cnt++;
            if (UP_M !== exp_up || DN_M !== exp_dn)
                $display("FAIL random[%0d]: got UP_M,DN_M=%b%b, want %b%b (a=%b up=%b dn=%b)",
                         i, UP_M, DN_M, exp_up, exp_dn, a, up, dn);
            else pass_cnt++;
        end
    endtask

    initial begin
        test_reset();
        test_open();
        test_close();
        test_illegal();
        test_activate_ignored();
        test_async_reset();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
